// File: rtl/post_proc_ctrl.sv
// Pass sequencer for the quantizer -> ReLU -> post-proc mux path into output_memory.
// Define POST_PROC_STATS_EN to add the stat_zeroed ReLU-clamp counter.
module post_proc_ctrl #(
  parameter int unsigned AW       = 10,
  parameter int unsigned CW       = 11,
  parameter int unsigned PIPE_LAT = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          cfg_relu_en,
  input  logic [AW-1:0] cfg_base_addr,
  input  logic [CW-1:0] cfg_count,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          quant_sign,
  output logic          dp_relu_en,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic          busy,
  output logic          done
`ifdef POST_PROC_STATS_EN
  ,
  output logic [CW-1:0] stat_zeroed
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

  state_t              state_q, state_d;
  logic                busy_d, done_d;
  logic                start_acc, accept, last_acc, drain_ok;
  logic [CW-1:0]       idx_q, cnt_q;
  logic [AW-1:0]       base_q;
  logic [PIPE_LAT-1:0] line_v;
  logic [AW-1:0]       line_a [PIPE_LAT];

  assign in_ready  = (state_q == RUN);
  assign accept    = in_valid & in_ready;
  assign last_acc  = accept & (idx_q == cnt_q - CW'(1));
  // A start landing on the done cycle is dropped so passes never overlap.
  assign start_acc = start & ~done & (state_q == IDLE);

  // Leave DRAIN once the last word is within two stages of the output, so
  // done lands the cycle after the final write with the line empty.
  if (PIPE_LAT > 2) begin : g_drain_deep
    assign drain_ok = ~|line_v[PIPE_LAT-3:0];
  end else begin : g_drain_short
    assign drain_ok = 1'b1;
  end

  // Next-state and registered-output decode
  always_comb begin
    state_d = state_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_acc) begin
          busy_d  = 1'b1;
          state_d = (cfg_count == '0) ? FIN : RUN;
        end
      end
      RUN: begin
        busy_d = 1'b1;
        if (last_acc) state_d = DRAIN;
      end
      DRAIN: begin
        busy_d = 1'b1;
        if (drain_ok) state_d = FIN;
      end
      FIN: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, status and latched pass configuration
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      dp_relu_en <= 1'b0;
      base_q     <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
    end else begin
      state_q <= state_d;
      busy    <= busy_d;
      done    <= done_d;
      if (start_acc) begin
        dp_relu_en <= cfg_relu_en;
        base_q     <= cfg_base_addr;
        cnt_q      <= cfg_count;
        idx_q      <= '0;
      end else if (accept) begin
        idx_q <= idx_q + CW'(1);
      end
    end
  end

  // Write strobe/address delay line; its last stage is the output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_v <= '0;
      for (int i = 0; i < int'(PIPE_LAT); i++) line_a[i] <= '0;
    end else begin
      line_v[0] <= accept;
      line_a[0] <= base_q + AW'(idx_q);
      for (int i = 1; i < int'(PIPE_LAT); i++) begin
        line_v[i] <= line_v[i-1];
        line_a[i] <= line_a[i-1];
      end
    end
  end

  assign wr_en   = line_v[PIPE_LAT-1];
  assign wr_addr = line_a[PIPE_LAT-1];

`ifdef POST_PROC_STATS_EN
  // Count words the ReLU clamps to zero (negative input on the ReLU path)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_zeroed <= '0;
    end else if (start_acc) begin
      stat_zeroed <= '0;
    end else if (wr_en & dp_relu_en & quant_sign) begin
      stat_zeroed <= stat_zeroed + CW'(1);
    end
  end
`else
  logic unused_quant_sign;
  assign unused_quant_sign = quant_sign;
`endif

endmodule

// File: tb/tb_post_proc_ctrl.sv
// Self-checking bench for post_proc_ctrl: pass table, corner sequences and a
// random phase, all compared cycle by cycle against a schedule-based model.
module tb_post_proc_ctrl;
  localparam int unsigned AW       = 10;
  localparam int unsigned CW       = 11;
  localparam int unsigned PIPE_LAT = 2;
  localparam int          NEVER    = 32'h7fff_ffff;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          cfg_relu_en = 1'b0;
  logic [AW-1:0] cfg_base_addr = '0;
  logic [CW-1:0] cfg_count = '0;
  logic          in_valid = 1'b0;
  logic          quant_sign = 1'b0;
  logic          in_ready, dp_relu_en, wr_en, busy, done;
  logic [AW-1:0] wr_addr;
`ifdef POST_PROC_STATS_EN
  logic [CW-1:0] stat_zeroed;
`endif

  always #5 clk = ~clk;

  post_proc_ctrl #(.AW(AW), .CW(CW), .PIPE_LAT(PIPE_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_relu_en(cfg_relu_en),
    .cfg_base_addr(cfg_base_addr), .cfg_count(cfg_count), .in_valid(in_valid),
    .in_ready(in_ready), .quant_sign(quant_sign), .dp_relu_en(dp_relu_en),
    .wr_en(wr_en), .wr_addr(wr_addr), .busy(busy), .done(done)
`ifdef POST_PROC_STATS_EN
    , .stat_zeroed(stat_zeroed)
`endif
  );

  typedef struct {
    logic          relu;
    logic [AW-1:0] base;
    logic [CW-1:0] cnt;
    logic [7:0]    pat;
    int            nwr;
    logic [AW-1:0] first;
    logic [AW-1:0] last;
    int            lat;
  } vec_t;

  vec_t tbl [$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;

  // Reference model: expected write schedule plus pass bookkeeping
  bit            m_acc;
  int            m_idx, m_cnt, m_start_cyc, m_done_at, m_stat;
  logic          m_relu;
  logic [AW-1:0] m_base;
  int            wq_cyc [$];
  logic [AW-1:0] wq_addr [$];

  // Observations for pass-level checks
  int            obs_nwr, obs_done_cyc;
  bit            done_seen;
  logic [AW-1:0] obs_first, obs_last;

  function automatic vec_t mk(input logic relu, input logic [AW-1:0] base, input logic [CW-1:0] cnt,
                              input logic [7:0] pat, input int nwr, input logic [AW-1:0] first,
                              input logic [AW-1:0] last, input int lat);
    vec_t v;
    v.relu = relu; v.base = base; v.cnt = cnt; v.pat = pat;
    v.nwr = nwr; v.first = first; v.last = last; v.lat = lat;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_acc = 1'b0; m_idx = 0; m_cnt = 0; m_relu = 1'b0; m_base = '0; m_stat = 0;
    m_start_cyc = NEVER; m_done_at = -1;
    wq_cyc.delete(); wq_addr.delete();
  endtask

  // Check current cycle at the falling edge, advance the model, move to the next cycle
  task automatic cycle_step();
    logic          exp_wr, exp_busy, exp_done;
    logic [AW-1:0] exp_addr;
    @(negedge clk);
    exp_wr = 1'b0;
    exp_addr = '0;
    if (wq_cyc.size() > 0) begin
      if (wq_cyc[0] == cyc) begin
        exp_wr = 1'b1;
        exp_addr = wq_addr[0];
      end
    end
    exp_done = (cyc == m_done_at);
    exp_busy = (m_start_cyc < cyc) && (cyc < m_done_at);
    chk("in_ready", 32'(in_ready), 32'(m_acc));
    chk("wr_en", 32'(wr_en), 32'(exp_wr));
    chk("busy", 32'(busy), 32'(exp_busy));
    chk("done", 32'(done), 32'(exp_done));
    chk("dp_relu_en", 32'(dp_relu_en), 32'(m_relu));
    if (exp_wr) begin
      chk("wr_addr", 32'(wr_addr), 32'(exp_addr));
      void'(wq_cyc.pop_front());
      void'(wq_addr.pop_front());
    end
`ifdef POST_PROC_STATS_EN
    chk("stat_zeroed", 32'(stat_zeroed), 32'(m_stat));
`endif
    if (wr_en) begin
      obs_nwr++;
      if (obs_nwr == 1) obs_first = wr_addr;
      obs_last = wr_addr;
    end
    if (done) begin
      done_seen = 1'b1;
      obs_done_cyc = cyc;
    end
    if (m_acc && in_valid) begin
      wq_cyc.push_back(cyc + int'(PIPE_LAT));
      wq_addr.push_back(m_base + AW'(m_idx));
      m_idx++;
      if (m_idx == m_cnt) begin
        m_acc = 1'b0;
        m_done_at = cyc + int'(PIPE_LAT) + 1;
      end
    end
    if (exp_wr && m_relu && quant_sign) m_stat++;
    if (start && !exp_busy && !exp_done) begin
      m_relu = cfg_relu_en; m_base = cfg_base_addr; m_cnt = int'(cfg_count);
      m_idx = 0; m_stat = 0; m_start_cyc = cyc;
      if (m_cnt == 0) m_done_at = cyc + 2;
      else begin
        m_acc = 1'b1;
        m_done_at = NEVER;
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  // One table pass, with ignored starts while busy and on the done cycle
  task automatic run_pass(input vec_t v);
    int s, k;
    obs_nwr = 0; done_seen = 1'b0; obs_done_cyc = 0; obs_first = '0; obs_last = '0;
    s = cyc;
    start = 1'b1; cfg_relu_en = v.relu; cfg_base_addr = v.base; cfg_count = v.cnt;
    in_valid = 1'b0; quant_sign = 1'($urandom);
    cycle_step();
    start = 1'b0;
    k = 0;
    while (!done_seen && k < 5000) begin
      in_valid = v.pat[k % 8];
      quant_sign = 1'($urandom);
      if (k == 2 || k == v.lat - 1) begin
        start = 1'b1; cfg_relu_en = ~v.relu; cfg_base_addr = ~v.base; cfg_count = CW'(7);
      end
      cycle_step();
      start = 1'b0;
      k++;
    end
    in_valid = 1'b0;
    chk("pass_done_seen", 32'(done_seen), 32'd1);
    chk("pass_done_latency", 32'(obs_done_cyc - s), 32'(v.lat));
    chk("pass_write_count", 32'(obs_nwr), 32'(v.nwr));
    if (v.nwr > 0) begin
      chk("pass_first_addr", 32'(obs_first), 32'(v.first));
      chk("pass_last_addr", 32'(obs_last), 32'(v.last));
    end
    chk("pass_relu_hold", 32'(dp_relu_en), 32'(v.relu));
    repeat (2) cycle_step();
  endtask

`ifdef POST_PROC_STATS_EN
  // Five writes carrying sign pattern 1,0,1,1,0; sign held high outside writes
  task automatic run_stat(input logic relu, input int exp);
    logic [4:0] qs;
    int k;
    qs = 5'b01101;
    done_seen = 1'b0;
    start = 1'b1; cfg_relu_en = relu; cfg_base_addr = 10'h040; cfg_count = CW'(5);
    in_valid = 1'b0; quant_sign = 1'b1;
    cycle_step();
    start = 1'b0;
    k = 0;
    while (!done_seen && k < 100) begin
      in_valid = 1'b1;
      quant_sign = (k >= 2 && k <= 6) ? qs[k-2] : 1'b1;
      cycle_step();
      k++;
    end
    in_valid = 1'b0;
    chk("stat_done_seen", 32'(done_seen), 32'd1);
    chk("stat_final", 32'(stat_zeroed), 32'(exp));
    repeat (2) cycle_step();
    chk("stat_stable", 32'(stat_zeroed), 32'(exp));
  endtask
`endif

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl.push_back(mk(1'b1, 10'h010, 11'd4,    8'hFF, 4,    10'h010, 10'h013, 7));
    tbl.push_back(mk(1'b0, 10'h100, 11'd3,    8'h15, 3,    10'h100, 10'h102, 8));
    tbl.push_back(mk(1'b1, 10'h3FE, 11'd4,    8'hFF, 4,    10'h3FE, 10'h001, 7));
    tbl.push_back(mk(1'b0, 10'h055, 11'd0,    8'hFF, 0,    10'h000, 10'h000, 2));
    tbl.push_back(mk(1'b1, 10'h3FF, 11'd1,    8'h80, 1,    10'h3FF, 10'h3FF, 11));
    tbl.push_back(mk(1'b0, 10'h200, 11'd5,    8'h55, 5,    10'h200, 10'h204, 12));
    tbl.push_back(mk(1'b1, 10'h000, 11'd2047, 8'hFF, 2047, 10'h000, 10'h3FE, 2050));

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", 32'(in_ready), 32'd0);
    chk("reset_wr_en", 32'(wr_en), 32'd0);
    chk("reset_wr_addr", 32'(wr_addr), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_relu", 32'(dp_relu_en), 32'd0);
    rst_n = 1'b1;
    repeat (2) cycle_step();

    foreach (tbl[i]) run_pass(tbl[i]);

    // Random traffic with stray starts, gaps and random signs
    for (int i = 0; i < 1500; i++) begin
      start = ($urandom_range(0, 5) == 0);
      cfg_relu_en = 1'($urandom);
      cfg_base_addr = AW'($urandom);
      cfg_count = CW'($urandom_range(0, 24));
      in_valid = ($urandom_range(0, 3) != 0);
      quant_sign = 1'($urandom);
      cycle_step();
    end
    start = 1'b0;
    in_valid = 1'b1;
    repeat (60) cycle_step();
    in_valid = 1'b0;
    repeat (3) cycle_step();

    // Reset in the middle of a pass after two accepts
    start = 1'b1; cfg_relu_en = 1'b1; cfg_base_addr = 10'h123; cfg_count = CW'(6);
    in_valid = 1'b0;
    cycle_step();
    start = 1'b0;
    in_valid = 1'b1;
    repeat (2) cycle_step();
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    chk("midrst_wr_en", 32'(wr_en), 32'd0);
    chk("midrst_wr_addr", 32'(wr_addr), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_relu", 32'(dp_relu_en), 32'd0);
    model_reset();
    repeat (2) cycle_step();
    rst_n = 1'b1;
    repeat (4) cycle_step();
    run_pass(mk(1'b0, 10'h020, 11'd2, 8'hFF, 2, 10'h020, 10'h021, 5));

`ifdef POST_PROC_STATS_EN
    run_stat(1'b1, 3);
    run_stat(1'b0, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
